fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined ARM core. It sits directly upstream of `instruction_memory`: it owns the program counter, drives `inst_address`/`inst_read` into the memory, and captures the returned big-endian word into the IF/ID pipeline register for decode. It also handles stalls and branch redirects from later stages.

---
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC, two-phase fetch FSM and IF/ID register.
// Drives a strobed big-endian instruction memory; handles stall/branch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_address,
  output logic        inst_read,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic {
    S_SETUP = 1'b0,
    S_READ  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] br_pc;
  logic        capture;

  assign pc_inc  = (pc + 32'd4) & ADDR_MASK;
  assign br_pc   = branch_target & 32'hFFFF_FFFC & ADDR_MASK;
  assign capture = (state == S_READ) && !stall && !branch_valid;

  assign inst_address = pc;

  // Fetch FSM: address setup phase, then a registered read strobe phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_SETUP;
      inst_read <= 1'b0;
      pc        <= RESET_PC;
    end else if (branch_valid) begin
      state     <= S_SETUP;
      inst_read <= 1'b0;
      pc        <= br_pc;
    end else begin
      unique case (state)
        S_SETUP: begin
          if (!stall) begin
            state     <= S_READ;
            inst_read <= 1'b1;
          end
        end
        S_READ: begin
          state     <= S_SETUP;
          inst_read <= 1'b0;
          if (!stall) pc <= pc_inc;
        end
      endcase
    end
  end

  // IF/ID register: capture on a completed read, hold under stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= 32'h0;
      if_id_pc    <= 32'h0;
    end else if (branch_valid) begin
      if_id_valid <= 1'b0;
    end else if (capture) begin
      if_id_valid <= 1'b1;
      if_id_inst  <= inst_in;
      if_id_pc    <= pc;
    end else if (!stall) begin
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus capture scoreboard for fetch_stage.
// Includes a behavioural strobed instruction memory.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] inst_in;
  logic [31:0] inst_address;
  logic        inst_read;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;

  int checks;
  int failures;

  logic [31:0] mem [8];

  localparam logic [31:0] W0 = 32'hE0813002;
  localparam logic [31:0] W1 = 32'hE20451B8;
  localparam logic [31:0] W2 = 32'hE3A00001;
  localparam logic [31:0] W3 = 32'hE3A01002;
  localparam logic [31:0] W4 = 32'hE7918109;
  localparam logic [31:0] W5 = 32'hE5801000;
  localparam logic [31:0] W6 = 32'hE2800004;
  localparam logic [31:0] W7 = 32'hEAFFFFFE;

  typedef struct {
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        rd;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] ipc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t vecs [16];
  exp_t sb_q [$];

  fetch_stage #(
    .RESET_PC (32'h0),
    .MEM_BYTES(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .inst_in      (inst_in),
    .inst_address (inst_address),
    .inst_read    (inst_read),
    .if_id_valid  (if_id_valid),
    .if_id_inst   (if_id_inst),
    .if_id_pc     (if_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory updates its output on the rising read strobe
  always @(posedge inst_read)
    inst_in <= mem[inst_address[4:2]];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    logic prev_v;
    checks   = 0;
    failures = 0;
    mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3;
    mem[4] = W4; mem[5] = W5; mem[6] = W6; mem[7] = W7;

    vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h04, 1'b1, W0,    32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, W0,    32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h08, 1'b1, W1,    32'h4};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h08, 1'b1, W1,    32'h4};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h08, 1'b1, W1,    32'h4};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h08, 1'b1, W1,    32'h4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 1'b0, W1,    32'h4};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h08, 1'b0, W1,    32'h4};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 1'b0, W1,    32'h4};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0C, 1'b1, W2,    32'h8};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b0, W2,    32'h8};
    vecs[12] = '{1'b1, 1'b1, 32'h13, 1'b0, 32'h10, 1'b0, W2,    32'h8};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, W2,    32'h8};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h14, 1'b1, W4,    32'h10};
    vecs[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b0, W4,    32'h10};

    reset         = 1'b1;
    stall         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'h0;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_read",  {31'h0, inst_read},   32'h0);
    chk("rst_addr",  inst_address,         32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_inst",  if_id_inst,           32'h0);
    chk("rst_pc",    if_id_pc,             32'h0);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      stall         = vecs[i].stl;
      branch_valid  = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_read", i),  {31'h0, inst_read},   {31'h0, vecs[i].rd});
      chk($sformatf("v%0d_addr", i),  inst_address,         vecs[i].addr);
      chk($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].vld});
      chk($sformatf("v%0d_inst", i),  if_id_inst,           vecs[i].inst);
      chk($sformatf("v%0d_pc", i),    if_id_pc,             vecs[i].ipc);
      @(negedge clk);
    end

    stall        = 1'b0;
    branch_valid = 1'b0;

    // mid-cycle reset while in the read phase
    reset = 1'b1;
    #1;
    chk("mid_rst_read",  {31'h0, inst_read},   32'h0);
    chk("mid_rst_addr",  inst_address,         32'h0);
    chk("mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("mid_rst_inst",  if_id_inst,           32'h0);
    chk("mid_rst_pc",    if_id_pc,             32'h0);
    @(negedge clk);
    reset = 1'b0;

    sb_q.delete();
    for (int k = 0; k < 9; k++) begin
      e.pc   = 32'((4 * k) % 32);
      e.inst = mem[k % 8];
      sb_q.push_back(e);
    end

    prev_v = 1'b0;
    for (int ed = 1; ed <= 18; ed++) begin
      @(posedge clk);
      #1;
      chk($sformatf("seq%0d_read", ed), {31'h0, inst_read},
          (ed % 2 == 1) ? 32'h1 : 32'h0);
      if (ed == 2)
        chk("seq2_addr", inst_address, 32'h4);
      if (if_id_valid && !prev_v) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra actual_pc=%h expected=none", if_id_pc);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("sb%0d_pc", ed),   if_id_pc,   e.pc);
          chk($sformatf("sb%0d_inst", ed), if_id_inst, e.inst);
        end
      end
      prev_v = if_id_valid;
    end
    chk("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
